sampling_vae_pipe: RTL and testbench

SAMPLING_VAE_PIPE -- requirements
Module: sampling_vae_pipe

---
 rtl/sampling_vae_pkg.sv | 46 ++++
 rtl/vae_lfsr16.sv | 45 ++++
 rtl/sampling_vae_pipe.sv | 172 +++++++++++++++++
 tb/tb_sampling_vae_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampling_vae_pkg.sv
// ============================================================================
// Module : sampling_vae_pkg
// Brief  : Q4.11 constants, piecewise-linear sqrt table, LFSR and mode encodings
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sampling_vae_pkg;

  localparam int Q_BITS    = 16;
  localparam int Q_FRAC    = 11;
  localparam int N_BREAKS  = 8;
  localparam int N_REGIONS = 9;

  // Breakpoints x1..x8 and per-region slope/intercept of the sqrt approximation
  localparam logic [15:0] X_TBL [N_BREAKS] = '{
    16'h0080, 16'h0100, 16'h0200, 16'h0400,
    16'h1000, 16'h2000, 16'h4000, 16'h6000
  };
  localparam logic [15:0] M_TBL [N_REGIONS] = '{
    16'h2000, 16'h0D42, 16'h095F, 16'h06A1, 16'h0400,
    16'h0258, 16'h01A8, 16'h0146, 16'h0112
  };
  localparam logic [15:0] C_TBL [N_REGIONS] = '{
    16'h0000, 16'h012C, 16'h01A8, 16'h0258, 16'h03EA,
    16'h06A1, 16'h095F, 16'h0C73, 16'h0EDA
  };

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] SEED_STRIDE = 16'h1F35;

  localparam logic [1:0] MODE_RAND = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_FIX  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // An all-zero state would lock the LFSR, so it is remapped to 1
  function automatic logic [15:0] lane_seed(input logic [15:0] base, input int unsigned lane);
    logic [15:0] s;
    s = base ^ 16'(lane * 32'(SEED_STRIDE));
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vae_lfsr16.sv
// ============================================================================
// Module : vae_lfsr16
// Brief  : 16-bit right-shifting Galois LFSR with load priority over step
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vae_lfsr16
  import sampling_vae_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

`default_nettype wire

// File: rtl/sampling_vae_pipe.sv
// ============================================================================
// Module : sampling_vae_pipe
// Brief  : 5-stage reparameterisation sampler a = ac + sqrt_pwl(ad) * eps
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sampling_vae_pipe
  import sampling_vae_pkg::*;
#(
  parameter int          N_LANES   = 2,
  parameter int          BITSIZE   = Q_BITS,
  parameter int          FRAC      = Q_FRAC,
  parameter logic [15:0] SEED_BASE = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_LANES*BITSIZE-1:0]   ac,
  input  logic [N_LANES*BITSIZE-1:0]   ad,
  input  logic [1:0]                   mode,
  input  logic [BITSIZE-1:0]           eps_fix,
  input  logic                         seed_load,
  input  logic [BITSIZE-1:0]           seed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_LANES*BITSIZE-1:0]   a,
  output logic [N_LANES*BITSIZE-1:0]   epsilon,
  output logic [31:0]                  sample_cnt
);

  typedef logic signed [BITSIZE-1:0] word_t;

  localparam word_t SAT_MAX = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam word_t SAT_MIN = {1'b1, {(BITSIZE-1){1'b0}}};

  function automatic word_t sat_mul(input word_t x, input word_t y);
    logic signed [2*BITSIZE-1:0] p;
    p = x * y;
    p = p >>> FRAC;
    if (&p[2*BITSIZE-1:BITSIZE-1] || ~|p[2*BITSIZE-1:BITSIZE-1]) begin
      return p[BITSIZE-1:0];
    end
    return p[2*BITSIZE-1] ? SAT_MIN : SAT_MAX;
  endfunction

  function automatic word_t sat_add(input word_t x, input word_t y);
    logic signed [BITSIZE:0] s;
    s = {x[BITSIZE-1], x} + {y[BITSIZE-1], y};
    if (s[BITSIZE] == s[BITSIZE-1]) begin
      return s[BITSIZE-1:0];
    end
    return s[BITSIZE] ? SAT_MIN : SAT_MAX;
  endfunction

  logic        adv;
  logic        accept;
  logic        lfsr_step;
  logic [4:1]  vld_q;
  logic        out_valid_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // One enable for every stage: the pipe only moves when the output slot frees
  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && adv;
  assign lfsr_step = accept && ((mode == MODE_RAND) || (mode == MODE_RSVD));
  assign cnt_d     = (out_valid_q && out_ready) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (adv) begin
        vld_q       <= {vld_q[3:1], accept};
        out_valid_q <= vld_q[4];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign sample_cnt = cnt_q;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [15:0] lfsr_state;
    logic [2:0]  lfsr_unused;
    word_t       ad_w, ac_w, m_w, c_w, eps_w;
    word_t       ad1_q, ac1_q, m1_q, c1_q, eps1_q;
    word_t       pm2_q, c2_q, ac2_q, eps2_q;
    word_t       sig3_q, ac3_q, eps3_q;
    word_t       se4_q, ac4_q, eps4_q;
    word_t       a_q, eps5_q;
    logic        pos1_q, pos2_q;

    vae_lfsr16 #(
      .RESET_SEED (lane_seed(SEED_BASE, i))
    ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (lfsr_step),
      .load_i  (seed_load),
      .seed_i  (lane_seed(16'(seed), i)),
      .state_o (lfsr_state)
    );

    assign lfsr_unused = lfsr_state[15:13];
    assign ad_w = ad[i*BITSIZE +: BITSIZE];
    assign ac_w = ac[i*BITSIZE +: BITSIZE];

    // Descending scan so the smallest matching breakpoint wins
    always_comb begin
      m_w = BITSIZE'($signed(M_TBL[N_REGIONS-1]));
      c_w = BITSIZE'($signed(C_TBL[N_REGIONS-1]));
      for (int k = N_BREAKS - 1; k >= 0; k--) begin
        if (ad_w < BITSIZE'($signed(X_TBL[k]))) begin
          m_w = BITSIZE'($signed(M_TBL[k]));
          c_w = BITSIZE'($signed(C_TBL[k]));
        end
      end
    end

    always_comb begin
      case (mode)
        MODE_ZERO: eps_w = '0;
        MODE_FIX:  eps_w = eps_fix;
        default:   eps_w = {{(BITSIZE-13){lfsr_state[12]}}, lfsr_state[12:0]};
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        {ad1_q, ac1_q, m1_q, c1_q, eps1_q} <= '0;
        {pm2_q, c2_q, ac2_q, eps2_q}       <= '0;
        {sig3_q, ac3_q, eps3_q}            <= '0;
        {se4_q, ac4_q, eps4_q}             <= '0;
        {a_q, eps5_q}                      <= '0;
        {pos1_q, pos2_q}                   <= '0;
      end else if (adv) begin
        ad1_q  <= ad_w;
        ac1_q  <= ac_w;
        m1_q   <= m_w;
        c1_q   <= c_w;
        eps1_q <= eps_w;
        pos1_q <= (ad_w > 0);
        pm2_q  <= sat_mul(ad1_q, m1_q);
        c2_q   <= c1_q;
        ac2_q  <= ac1_q;
        eps2_q <= eps1_q;
        pos2_q <= pos1_q;
        sig3_q <= pos2_q ? sat_add(pm2_q, c2_q) : '0;
        ac3_q  <= ac2_q;
        eps3_q <= eps2_q;
        se4_q  <= sat_mul(sig3_q, eps3_q);
        ac4_q  <= ac3_q;
        eps4_q <= eps3_q;
        a_q    <= sat_add(se4_q, ac4_q);
        eps5_q <= eps4_q;
      end
    end

    assign a[i*BITSIZE +: BITSIZE]       = a_q;
    assign epsilon[i*BITSIZE +: BITSIZE] = eps5_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_sampling_vae_pipe.sv
// ============================================================================
// Module : tb_sampling_vae_pipe
// Brief  : scoreboard bench for sampling_vae_pipe with directed vectors
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sampling_vae_pipe;

  localparam int NL = 2;
  localparam int B  = 16;
  localparam int W  = NL * B;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, seed_load, out_valid, out_ready;
  logic [W-1:0]  ac, ad, a, epsilon;
  logic [1:0]    mode;
  logic [B-1:0]  eps_fix, seed;
  logic [31:0]   sample_cnt;

  always #5 clk = ~clk;

  sampling_vae_pipe #(
    .N_LANES   (NL),
    .BITSIZE   (B),
    .FRAC      (11),
    .SEED_BASE (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ac         (ac),
    .ad         (ad),
    .mode       (mode),
    .eps_fix    (eps_fix),
    .seed_load  (seed_load),
    .seed       (seed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a          (a),
    .epsilon    (epsilon),
    .sample_cnt (sample_cnt)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] e;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] obs_eps[$];
  logic [W-1:0] run_eps [2][5];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           exp_cnt  = 0;
  bit           hold_pending = 1'b0;
  logic [W-1:0] hold_a, hold_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [15:0] sx13(input logic [15:0] s);
    return {{3{s[12]}}, s[12:0]};
  endfunction

  // Monitor: compares every output handshake and checks stall stability
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (hold_pending) begin
          chk("stall_hold_a", 64'(a), 64'(hold_a));
          chk("stall_hold_eps", 64'(epsilon), 64'(hold_e));
        end
        if (out_ready) begin
          hold_pending = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_a", 64'(a), 64'(e.a));
            chk("out_epsilon", 64'(epsilon), 64'(e.e));
            obs_eps.push_back(epsilon);
          end
        end else begin
          hold_pending = 1'b1;
          hold_a = a;
          hold_e = epsilon;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  task automatic send(input logic [1:0] md, input logic [W-1:0] acv, input logic [W-1:0] adv_,
                      input logic [B-1:0] ef, input logic [W-1:0] ea, input logic [W-1:0] ee,
                      input logic sl, input logic [B-1:0] sd);
    bit ok;
    exp_t e;
    mode = md; ac = acv; ad = adv_; eps_fix = ef; seed_load = sl; seed = sd;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid  = 1'b0;
    seed_load = 1'b0;
    if (!ok) begin
      chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
    end else begin
      e.a = ea;
      e.e = ee;
      sb.push_back(e);
      exp_cnt++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before any clock edge
  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    sb.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic seed_run(input int r);
    logic [15:0] l0, l1;
    apply_reset();
    obs_eps.delete();
    send(2'b00, 32'h0022_0011, 32'h0, 16'h0, 32'h0022_0011, 32'hF3D4_0CE1, 1'b1, 16'h1234);
    l0 = 16'h1234;
    l1 = 16'h0D01;
    for (int j = 0; j < 4; j++) begin
      send(j[0] ? 2'b11 : 2'b00, 32'h0022_0011, 32'h0, 16'h0, 32'h0022_0011,
           {sx13(l1), sx13(l0)}, 1'b0, 16'h0);
      l0 = lfsr_next(l0);
      l1 = lfsr_next(l1);
    end
    drain();
    chk("seed_obs_count", 64'(obs_eps.size()), 64'd5);
    for (int j = 0; j < 5; j++) run_eps[r][j] = (j < obs_eps.size()) ? obs_eps[j] : '0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
    ac = '0; ad = '0; mode = 2'b00; eps_fix = '0; seed = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_sample_cnt", 64'(sample_cnt), 64'd0);
    chk("init_a", 64'(a), 64'd0);
    chk("init_epsilon", 64'(epsilon), 64'd0);
    chk("init_in_ready", 64'(in_ready), 64'd1);

    // eps = 0: a passes ac through, check exact latency
    send(2'b01, 32'hFC00_0400, 32'h0800_0800, 16'h0, 32'hFC00_0400, 32'h0, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("latency_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("latency_5", 64'(out_valid), 64'd1);
    drain();

    // ad = 1.0 lands in region 5: sigma = m5 + c5
    send(2'b10, 32'h0, 32'h0800_0800, 16'h0800, 32'h07EA_07EA, 32'h0800_0800, 1'b0, 16'h0);
    // saturation both directions
    send(2'b10, 32'h7000_7000, 32'h7FFF_7FFF, 16'h1000, 32'h7FFF_7FFF, 32'h1000_1000, 1'b0, 16'h0);
    send(2'b10, 32'h9000_9000, 32'h7FFF_7FFF, 16'hF000, 32'h8000_8000, 32'hF000_F000, 1'b0, 16'h0);
    // ad <= 0 forces sigma to 0
    send(2'b10, 32'h0123_0123, 32'h8000_0000, 16'h0800, 32'h0123_0123, 32'h0800_0800, 1'b0, 16'h0);
    // ad exactly on breakpoints x2 (region 3) and x6 (region 7), positive and negative eps
    send(2'b10, 32'h0, 32'h2000_0100, 16'h0800, 32'h0FFF_02D3, 32'h0800_0800, 1'b0, 16'h0);
    send(2'b10, 32'h0, 32'h2000_0100, 16'hF800, 32'hF001_FD2D, 32'hF800_F800, 1'b0, 16'h0);
    drain();
    chk("cnt_after_directed", 64'(sample_cnt), 64'(exp_cnt));

    // back-to-back stream with a 3-cycle output stall
    apply_reset();
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          logic [15:0] av;
          av = 16'((2026 * k) / 8 + 16 * k);
          send(2'b10, {16'(16 * k), 16'(16 * k)}, 32'h0800_0800, 16'(k * 256),
               {av, av}, {16'(k * 256), 16'(k * 256)}, 1'b0, 16'h0);
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_sample_cnt", 64'(sample_cnt), 64'd10);

    // reseed reproducibility
    seed_run(0);
    seed_run(1);
    for (int j = 0; j < 5; j++) chk("seed_repeat", 64'(run_eps[1][j]), 64'(run_eps[0][j]));
    chk("lanes_differ", 64'(run_eps[0][1][15:0] != run_eps[0][1][31:16]), 64'd1);

    // reset with samples in flight and one held at the output
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      send(2'b10, 32'h0, 32'h0800_0800, 16'h0800, 32'h07EA_07EA, 32'h0800_0800, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("inflight_out_valid", 64'(out_valid), 64'd1);
    apply_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk);
      #1;
      chk("no_stale_output", 64'(out_valid), 64'd0);
    end
    chk("post_reset_cnt", 64'(sample_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
